// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state type, key-size helpers,
// round-key extraction and the byte-level round primitives.
package aes_pkg;

    localparam int unsigned MAX_NR = 14;
    localparam int unsigned KS_W   = 128 * (MAX_NR + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } ctrl_state_t;

    // Number of rounds for a given key length in bits
    function automatic int unsigned nr_of(input int unsigned key_size);
        return key_size / 32 + 6;
    endfunction

    // Round key k: word 4k sits in the lowest 32 bits of its 128-bit slot,
    // but forms the most significant word of the round key
    function automatic logic [127:0] rk_select(input logic [KS_W-1:0] words,
                                               input logic [3:0]      k);
        logic [127:0] rk;
        int unsigned  base;
        base = 128 * {28'd0, k};
        for (int unsigned j = 0; j < 4; j++) begin
            rk[127-32*j -: 32] = words[base + 32*j +: 32];
        end
        return rk;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (b^254) followed by the affine map
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational. The final round
// bypasses MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // SubBytes on all 16 bytes, then ShiftRows: byte (row r, col c) takes column (c+r) mod 4
    always_comb begin
        sb = '0;
        sr = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sub_byte(state_in[127-8*i -: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    // MixColumns per column (skipped on the last round), then AddRoundKey
    always_comb begin
        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        state_out = (last ? sr : mc) ^ round_key;
    end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES encryption controller: one shared round datapath stepped
// Nr times per block, with valid/ready handshakes on both sides.
module aes_iter_ctrl
    import aes_pkg::*;
#(
    parameter  int unsigned KeySize = 128,
    localparam int unsigned NR      = nr_of(KeySize),
    localparam int unsigned WORDS_W = 128 * (NR + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       plaintext,
    input  logic [WORDS_W-1:0] words,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       ciphertext,
    output logic               busy
);

    localparam logic [3:0] NR4 = 4'(NR);

    ctrl_state_t        st;
    logic [3:0]         rnd;
    logic [127:0]       state_reg;
    logic [WORDS_W-1:0] key_store;
    logic [127:0]       rk_cur;
    logic [127:0]       rk_first;
    logic [127:0]       round_out;
    logic               last;
    logic               accept;

    // Handshake and round-key selection; in_ready passes out_ready through in DONE
    always_comb begin
        last       = (rnd == NR4);
        rk_cur     = rk_select(KS_W'(key_store), rnd);
        rk_first   = rk_select(KS_W'(words), 4'd0);
        in_ready   = (st == IDLE) || ((st == DONE) && out_ready);
        accept     = in_valid && in_ready;
        ciphertext = state_reg;
    end

    aes_round u_round (
        .state_in  (state_reg),
        .round_key (rk_cur),
        .last      (last),
        .state_out (round_out)
    );

    // Controller: block capture, round sequencing and result handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            key_store <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            // Covers both the idle accept and the DONE-cycle handoff-plus-accept
            key_store <= words;
            state_reg <= plaintext ^ rk_first;
            rnd       <= 4'd1;
            st        <= ROUND;
            busy      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (st)
                ROUND: begin
                    state_reg <= round_out;
                    if (last) begin
                        st        <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
